// File: rtl/ctrl_refresh_sched.sv
// ctrl_refresh_sched: multi-rank DDR refresh scheduler.
// Each rank has its own staggered tREFI counter, a refresh debt counter and a
// tRFC timer. Outputs are registered from next-state values, so each flag
// appears in the cycle right after the edge that causes it.
// Optional refresh pull-in on idle ranks: define REF_PULLIN_EN.
module ctrl_refresh_sched #(
    parameter int unsigned NUM_RANKS    = 2,
    parameter int unsigned T_REFI       = 6240,
    parameter int unsigned T_RFC        = 280,
    parameter int unsigned ALMOST_LEAD  = 100,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned MAX_PULLIN   = 8,
    parameter int unsigned OW_W         = $clog2(MAX_POSTPONE + 2)
) (
    input  logic                      CK_t,
    input  logic                      reset,
    input  logic                      clear_refresh,
    input  logic                      refresh_en,
    input  logic [NUM_RANKS-1:0]      rank_idle,
    input  logic [NUM_RANKS-1:0]      ref_ack,
    output logic [NUM_RANKS-1:0]      ref_req,
    output logic [NUM_RANKS-1:0]      ref_urgent,
    output logic [NUM_RANKS-1:0]      ref_almost,
    output logic [NUM_RANKS-1:0]      refresh_busy,
    output logic [NUM_RANKS-1:0]      refresh_done,
    output logic [NUM_RANKS*OW_W-1:0] owed_cnt,
    output logic                      err_overflow,
    output logic                      err_spurious
);

    localparam int unsigned CW = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int unsigned RW = (T_RFC > 1) ? $clog2(T_RFC) : 1;
    // Signed debt wide enough for both the postpone and the pull-in range.
    localparam int unsigned DW = OW_W + $clog2(MAX_PULLIN + 1) + 1;

    localparam logic signed [DW-1:0] SAT       = DW'(MAX_POSTPONE + 1);
    localparam logic signed [DW-1:0] NEG_LIM   = DW'(0) - DW'(MAX_PULLIN);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(T_REFI - 1);
    localparam logic [CW-1:0]        ALM_START = CW'(T_REFI - ALMOST_LEAD);
    localparam logic [RW-1:0]        RFC_LAST  = RW'(T_RFC - 1);

    typedef enum logic [1:0] {IDLE, PEND, BUSY} state_t;

    state_t                 state_q [NUM_RANKS];
    state_t                 state_d [NUM_RANKS];
    logic [CW-1:0]          cnt_q   [NUM_RANKS];
    logic [CW-1:0]          cnt_d   [NUM_RANKS];
    logic [RW-1:0]          rfc_q   [NUM_RANKS];
    logic [RW-1:0]          rfc_d   [NUM_RANKS];
    logic signed [DW-1:0]   debt_q  [NUM_RANKS];
    logic signed [DW-1:0]   debt_d  [NUM_RANKS];

    logic [NUM_RANKS-1:0]      wrap, ack_ok, spur, ovf, pos;
    logic [NUM_RANKS-1:0]      req_d, urg_d, alm_d, busy_d, done_d;
    logic [NUM_RANKS*OW_W-1:0] owed_d;

`ifndef REF_PULLIN_EN
    logic unused_idle;
    assign unused_idle = ^rank_idle;
`endif

    // Staggered interval start so ranks do not all come due together.
    function automatic logic [CW-1:0] start_cnt(int r);
        return CW'(r * int'(T_REFI / NUM_RANKS));
    endfunction

    // Next-state and next-output computation for every rank.
    always_comb begin
        cnt_d   = cnt_q;
        debt_d  = debt_q;
        rfc_d   = rfc_q;
        state_d = state_q;
        wrap    = '0;
        ack_ok  = '0;
        spur    = '0;
        ovf     = '0;
        pos     = '0;
        req_d   = '0;
        urg_d   = '0;
        alm_d   = '0;
        busy_d  = '0;
        done_d  = '0;
        owed_d  = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            wrap[r] = refresh_en && (cnt_q[r] == CNT_LAST);
            if (refresh_en) begin
                cnt_d[r] = wrap[r] ? '0 : cnt_q[r] + CW'(1);
            end
            ack_ok[r] = ref_ack[r] && ref_req[r];
            spur[r]   = ref_ack[r] && !ref_req[r];
            ovf[r]    = wrap[r] && (debt_q[r] == SAT);

            // Wrap and ack together cancel; a saturated wrap holds the debt.
            if (wrap[r] && !ack_ok[r] && !ovf[r]) begin
                debt_d[r] = debt_q[r] + DW'(1);
            end else if (ack_ok[r] && !wrap[r]) begin
                debt_d[r] = debt_q[r] - DW'(1);
            end
            pos[r] = !debt_d[r][DW-1] && (debt_d[r] != '0);

            if (ack_ok[r]) begin
                state_d[r] = BUSY;
                rfc_d[r]   = '0;
            end else if (state_q[r] == BUSY) begin
                if (rfc_q[r] == RFC_LAST) begin
                    done_d[r]  = 1'b1;
                    rfc_d[r]   = '0;
                    state_d[r] = pos[r] ? PEND : IDLE;
                end else begin
                    rfc_d[r] = rfc_q[r] + RW'(1);
                end
            end else begin
                state_d[r] = pos[r] ? PEND : IDLE;
            end

            busy_d[r] = (state_d[r] == BUSY);
`ifdef REF_PULLIN_EN
            req_d[r]  = !busy_d[r] && (pos[r] || (rank_idle[r] && (debt_d[r] > NEG_LIM)));
`else
            req_d[r]  = !busy_d[r] && pos[r];
`endif
            urg_d[r]  = !busy_d[r] && (debt_d[r] == SAT);
            alm_d[r]  = !busy_d[r] && (debt_d[r] == '0) && (cnt_d[r] >= ALM_START);
            owed_d[r*OW_W +: OW_W] = pos[r] ? debt_d[r][OW_W-1:0] : '0;

            // Synchronous clear behaves exactly like reset.
            if (clear_refresh) begin
                cnt_d[r]   = start_cnt(r);
                debt_d[r]  = '0;
                rfc_d[r]   = '0;
                state_d[r] = IDLE;
                req_d[r]   = 1'b0;
                urg_d[r]   = 1'b0;
                alm_d[r]   = 1'b0;
                busy_d[r]  = 1'b0;
                done_d[r]  = 1'b0;
                owed_d[r*OW_W +: OW_W] = '0;
            end
        end
    end

    // State and registered outputs; reset aborts any running tRFC silently.
    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_RANKS; r++) begin
                cnt_q[r]   <= start_cnt(r);
                debt_q[r]  <= '0;
                rfc_q[r]   <= '0;
                state_q[r] <= IDLE;
            end
            ref_req      <= '0;
            ref_urgent   <= '0;
            ref_almost   <= '0;
            refresh_busy <= '0;
            refresh_done <= '0;
            owed_cnt     <= '0;
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            debt_q       <= debt_d;
            rfc_q        <= rfc_d;
            state_q      <= state_d;
            ref_req      <= req_d;
            ref_urgent   <= urg_d;
            ref_almost   <= alm_d;
            refresh_busy <= busy_d;
            refresh_done <= done_d;
            owed_cnt     <= owed_d;
            err_overflow <= !clear_refresh && (err_overflow || (|ovf));
            err_spurious <= !clear_refresh && (err_spurious || (|spur));
        end
    end

endmodule

// File: tb/tb_ctrl_refresh_sched.sv
// Scoreboard bench for ctrl_refresh_sched with small timing parameters.
// Stimulus pushes (cycle, field, rank, value) expectations; the monitor
// compares each one in the cycle it falls due.
module tb_ctrl_refresh_sched;

    localparam int unsigned NR = 2;
    localparam int unsigned OW = 2;

    localparam int F_REQ  = 0;
    localparam int F_URG  = 1;
    localparam int F_ALM  = 2;
    localparam int F_BUSY = 3;
    localparam int F_DONE = 4;
    localparam int F_OWED = 5;
    localparam int F_OVF  = 6;
    localparam int F_SPUR = 7;

    logic            CK_t = 1'b0;
    logic            reset = 1'b1;
    logic            clear_refresh = 1'b0;
    logic            refresh_en = 1'b1;
    logic [NR-1:0]   rank_idle = '0;
    logic [NR-1:0]   ref_ack = '0;
    logic [NR-1:0]   ref_req, ref_urgent, ref_almost, refresh_busy, refresh_done;
    logic [NR*OW-1:0] owed_cnt;
    logic            err_overflow, err_spurious;

    ctrl_refresh_sched #(
        .NUM_RANKS(NR), .T_REFI(20), .T_RFC(5), .ALMOST_LEAD(4),
        .MAX_POSTPONE(2), .MAX_PULLIN(8)
    ) dut (
        .CK_t(CK_t), .reset(reset), .clear_refresh(clear_refresh),
        .refresh_en(refresh_en), .rank_idle(rank_idle), .ref_ack(ref_ack),
        .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_almost(ref_almost),
        .refresh_busy(refresh_busy), .refresh_done(refresh_done),
        .owed_cnt(owed_cnt), .err_overflow(err_overflow), .err_spurious(err_spurious)
    );

    always #5 CK_t = ~CK_t;

    typedef struct {
        int cyc;
        int fld;
        int rank;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   base  = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge CK_t) cyc <= cyc + 1;

    function automatic int sample(int fld, int r);
        case (fld)
            F_REQ:   return int'(ref_req[r]);
            F_URG:   return int'(ref_urgent[r]);
            F_ALM:   return int'(ref_almost[r]);
            F_BUSY:  return int'(refresh_busy[r]);
            F_DONE:  return int'(refresh_done[r]);
            F_OWED:  return int'(owed_cnt[r*OW +: OW]);
            F_OVF:   return int'(err_overflow);
            F_SPUR:  return int'(err_spurious);
            default: return -1;
        endcase
    endfunction

    function automatic string fname(int fld);
        case (fld)
            F_REQ:   return "ref_req";
            F_URG:   return "ref_urgent";
            F_ALM:   return "ref_almost";
            F_BUSY:  return "refresh_busy";
            F_DONE:  return "refresh_done";
            F_OWED:  return "owed_cnt";
            F_OVF:   return "err_overflow";
            F_SPUR:  return "err_spurious";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, flag any overdue.
    always @(negedge CK_t) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                total++;
                if (sample(sb[i].fld, sb[i].rank) != sb[i].val) begin
                    bad++;
                    $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d",
                             fname(sb[i].fld), sb[i].rank, sb[i].cyc - base,
                             sample(sb[i].fld, sb[i].rank), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s[%0d] cycle %0d: never sampled, expected %0d",
                         fname(sb[i].fld), sb[i].rank, sb[i].cyc - base, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic ex(int k, int fld, int r, int v);
        exp_t e;
        e.cyc  = base + k;
        e.fld  = fld;
        e.rank = r;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic goto(int k);
        while (cyc < base + k) @(negedge CK_t);
    endtask

    // Reset pulse; cycle 0 of the next scenario is the cycle right after release.
    task automatic do_reset();
        @(posedge CK_t);
        #2;
        reset         = 1'b1;
        ref_ack       = '0;
        clear_refresh = 1'b0;
        refresh_en    = 1'b1;
        rank_idle     = '0;
        repeat (2) @(posedge CK_t);
        #2;
        reset = 1'b0;
        base  = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release, first request timing, single refresh on rank 0.
        do_reset();
        ex(0, F_REQ, 0, 0);  ex(0, F_REQ, 1, 0);  ex(0, F_BUSY, 0, 0);
        ex(0, F_OWED, 0, 0); ex(0, F_OWED, 1, 0); ex(0, F_OVF, 0, 0);
        ex(0, F_SPUR, 0, 0); ex(0, F_ALM, 0, 0);  ex(0, F_URG, 0, 0);
        ex(15, F_ALM, 0, 0); ex(16, F_ALM, 0, 1); ex(19, F_ALM, 0, 1); ex(20, F_ALM, 0, 0);
        ex(19, F_REQ, 0, 0); ex(20, F_REQ, 0, 1); ex(20, F_OWED, 0, 1);
        ex(5, F_ALM, 1, 0);  ex(6, F_ALM, 1, 1);  ex(9, F_ALM, 1, 1);  ex(10, F_ALM, 1, 0);
        ex(9, F_REQ, 1, 0);  ex(10, F_REQ, 1, 1);
        ex(21, F_BUSY, 0, 0); ex(22, F_BUSY, 0, 1); ex(26, F_BUSY, 0, 1); ex(27, F_BUSY, 0, 0);
        ex(22, F_REQ, 0, 0); ex(21, F_OWED, 0, 1); ex(22, F_OWED, 0, 0);
        ex(26, F_DONE, 0, 0); ex(27, F_DONE, 0, 1); ex(28, F_DONE, 0, 0); ex(27, F_REQ, 0, 0);
        goto(21); ref_ack[0] = 1'b1;
        goto(22); ref_ack[0] = 1'b0;
        goto(30);

        // Debt accumulation on rank 0 up to saturation and overflow, then clear.
        do_reset();
        ex(19, F_OWED, 0, 0); ex(20, F_OWED, 0, 1); ex(39, F_OWED, 0, 1); ex(40, F_OWED, 0, 2);
        ex(59, F_OWED, 0, 2); ex(60, F_OWED, 0, 3); ex(80, F_OWED, 0, 3); ex(81, F_OWED, 0, 3);
        ex(59, F_URG, 0, 0);  ex(60, F_URG, 0, 1);  ex(81, F_URG, 0, 1);  ex(60, F_REQ, 0, 1);
        ex(79, F_OVF, 0, 0);  ex(80, F_OVF, 0, 1);  ex(82, F_OVF, 0, 1);
        ex(11, F_BUSY, 1, 1); ex(15, F_BUSY, 1, 1); ex(16, F_BUSY, 1, 0); ex(16, F_DONE, 1, 1);
        ex(83, F_OVF, 0, 0);  ex(83, F_OWED, 0, 0); ex(83, F_URG, 0, 0);  ex(83, F_REQ, 0, 0);
        for (int k = 10; k <= 70; k += 20) begin
            goto(k);     ref_ack[1] = 1'b1;
            goto(k + 1); ref_ack[1] = 1'b0;
        end
        goto(82); clear_refresh = 1'b1;
        goto(83); clear_refresh = 1'b0;
        goto(85);

        // Spurious ack on rank 1; ack coinciding with rank 0's wrap.
        do_reset();
        ex(3, F_SPUR, 0, 0);  ex(4, F_SPUR, 0, 1);  ex(44, F_SPUR, 0, 1);
        ex(4, F_BUSY, 1, 0);  ex(10, F_OWED, 1, 1);
        ex(39, F_OWED, 0, 1); ex(40, F_OWED, 0, 1); ex(39, F_REQ, 0, 1); ex(40, F_REQ, 0, 0);
        ex(40, F_BUSY, 0, 1); ex(44, F_BUSY, 0, 1); ex(45, F_BUSY, 0, 0);
        ex(45, F_DONE, 0, 1); ex(45, F_REQ, 0, 1);  ex(45, F_OWED, 0, 1);
        goto(3);  ref_ack[1] = 1'b1;
        goto(4);  ref_ack[1] = 1'b0;
        goto(39); ref_ack[0] = 1'b1;
        goto(40); ref_ack[0] = 1'b0;
        goto(47);

        // Reset asserted in the middle of a rank 0 refresh.
        do_reset();
        ex(6, F_SPUR, 0, 1);  ex(23, F_SPUR, 0, 1); ex(23, F_BUSY, 0, 1);
        ex(24, F_BUSY, 0, 0); ex(24, F_SPUR, 0, 0); ex(24, F_REQ, 1, 0); ex(24, F_OWED, 1, 0);
        ex(27, F_DONE, 0, 0); ex(27, F_BUSY, 0, 0); ex(27, F_REQ, 0, 0);
        goto(5);  ref_ack[0] = 1'b1;
        goto(6);  ref_ack[0] = 1'b0;
        goto(21); ref_ack[0] = 1'b1;
        goto(22); ref_ack[0] = 1'b0;
        goto(23);
        @(posedge CK_t);
        #2;
        reset = 1'b1;
        goto(29);

        // Interval counters frozen while refresh_en is low.
        do_reset();
        refresh_en = 1'b0;
        ex(20, F_REQ, 0, 0); ex(29, F_REQ, 0, 0); ex(30, F_REQ, 0, 1);
        ex(19, F_REQ, 1, 0); ex(20, F_REQ, 1, 1);
        ex(25, F_ALM, 0, 0); ex(26, F_ALM, 0, 1);
        goto(10); refresh_en = 1'b1;
        goto(32);

        repeat (2) @(negedge CK_t);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
